sprite_shifter: RTL and testbench

- Pixel-side consumer of the sprite fetch interface.
- During the sprite fetch window, receives per-slot attribute, X and pattern bytes for the next scanline's 8 sprites into 8 slot registers.
- During visible pixel cycles of that scanline, counts down each slot's X, shifts its pattern planes out, and resolves the front-most opaque sprite pixel.
- Output feeds the background/sprite priority mux and sprite-0-hit logic.

---
 rtl/sprite_shifter_if.sv | 37 +++
 rtl/sprite_shifter.sv | 156 +++++++++++++++
 tb/tb_sprite_shifter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_shifter_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_shifter_if
// Purpose  : Fetch-side load bus and pixel-side result bus of the sprite shifter
// Revision : 1.0 - initial release
// ============================================================================
interface sprite_shifter_if;
    logic       rend;
    logic [8:0] cycle;
    logic [8:0] scan;
    logic [7:0] ppumask;
    logic [7:0] sp_attr;
    logic [7:0] sp_x;
    logic       sp_zero;
    logic       sp_valid;
    logic [7:0] pat_din;
    logic       pat_lo_ld;
    logic       pat_hi_ld;
    logic [3:0] px_color;
    logic       px_pri;
    logic       px_sp0;

    modport master (
        output rend, cycle, scan, ppumask,
        output sp_attr, sp_x, sp_zero, sp_valid,
        output pat_din, pat_lo_ld, pat_hi_ld,
        input  px_color, px_pri, px_sp0
    );

    modport slave (
        input  rend, cycle, scan, ppumask,
        input  sp_attr, sp_x, sp_zero, sp_valid,
        input  pat_din, pat_lo_ld, pat_hi_ld,
        output px_color, px_pri, px_sp0
    );
endinterface
`default_nettype wire

// File: rtl/sprite_shifter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_shifter
// Purpose  : Eight sprite slots loaded in the fetch window, shifted out during
//            visible dots, front-most opaque pixel resolved and registered.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_shifter #(
    parameter int NSLOTS = 8
) (
    input  logic             clk,
    input  logic             rst,
    sprite_shifter_if.slave  sp_if
);

    localparam int c_SLOT_W = 3;

    logic [7:0]          plane0_q [NSLOTS];
    logic [7:0]          plane0_d [NSLOTS];
    logic [7:0]          plane1_q [NSLOTS];
    logic [7:0]          plane1_d [NSLOTS];
    logic [7:0]          xcnt_q   [NSLOTS];
    logic [7:0]          xcnt_d   [NSLOTS];
    logic [1:0]          pal_q    [NSLOTS];
    logic [1:0]          pal_d    [NSLOTS];
    logic [NSLOTS-1:0]   pri_q, pri_d;
    logic [NSLOTS-1:0]   sp0_q, sp0_d;
    logic [NSLOTS-1:0]   valid_q, valid_d;
    logic [3:0]          px_color_q, px_color_d;
    logic                px_pri_q, px_pri_d;
    logic                px_sp0_q, px_sp0_d;

    logic [1:0]          w_pix [NSLOTS];
    logic                w_in_win;
    logic                w_vis;
    logic                w_show;
    logic [8:0]          w_px_x;
    logic [c_SLOT_W-1:0] w_slot;
    logic [c_SLOT_W-1:0] w_win;
    logic                w_hit;
    logic [7:0]          w_din;
    logic                w_unused;

    function automatic logic [7:0] f_rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    assign w_in_win = (sp_if.cycle >= 9'd256) && (sp_if.cycle <= 9'd319);
    assign w_slot   = sp_if.cycle[5:3];
    assign w_vis    = sp_if.rend && (sp_if.scan <= 9'd239) &&
                      (sp_if.cycle >= 9'd1) && (sp_if.cycle <= 9'd256);
    assign w_px_x   = sp_if.cycle - 9'd1;
    assign w_show   = sp_if.ppumask[4] && !((w_px_x < 9'd8) && !sp_if.ppumask[2]);
    // H-flip is folded in at load time so the shifter always emits bit 7 first
    assign w_din    = sp_if.sp_attr[6] ? f_rev8(sp_if.pat_din) : sp_if.pat_din;
    assign w_unused = ^{sp_if.sp_attr[7], sp_if.sp_attr[4:2], sp_if.ppumask[7:5],
                        sp_if.ppumask[3], sp_if.ppumask[1:0]};

    for (genvar g = 0; g < NSLOTS; g++) begin : g_slot_pix
        assign w_pix[g] = (valid_q[g] && (xcnt_q[g] == 8'd0)) ?
                          {plane1_q[g][7], plane0_q[g][7]} : 2'b00;
    end

    // Descending scan so the lowest-index opaque slot is the last to claim the win
    always_comb begin
        w_hit = 1'b0;
        w_win = '0;
        for (int s = NSLOTS - 1; s >= 0; s--) begin
            if (w_pix[s] != 2'b00) begin
                w_hit = 1'b1;
                w_win = c_SLOT_W'(s);
            end
        end
    end

    always_comb begin
        plane0_d = plane0_q;
        plane1_d = plane1_q;
        xcnt_d   = xcnt_q;
        pal_d    = pal_q;
        pri_d    = pri_q;
        sp0_d    = sp0_q;
        valid_d  = valid_q;

        if (w_vis) begin
            for (int s = 0; s < NSLOTS; s++) begin
                if (xcnt_q[s] != 8'd0) begin
                    xcnt_d[s] = xcnt_q[s] - 8'd1;
                end else begin
                    plane0_d[s] = {plane0_q[s][6:0], 1'b0};
                    plane1_d[s] = {plane1_q[s][6:0], 1'b0};
                end
            end
        end

        if (w_in_win) begin
            if (sp_if.pat_lo_ld) begin
                plane0_d[w_slot] = w_din;
            end else if (sp_if.pat_hi_ld) begin
                plane1_d[w_slot] = sp_if.sp_valid ? w_din : 8'h00;
                if (!sp_if.sp_valid) plane0_d[w_slot] = 8'h00;
                xcnt_d[w_slot]   = sp_if.sp_x;
                pal_d[w_slot]    = sp_if.sp_attr[1:0];
                pri_d[w_slot]    = sp_if.sp_attr[5];
                sp0_d[w_slot]    = sp_if.sp_zero;
                valid_d[w_slot]  = sp_if.sp_valid;
            end
        end

        px_color_d = 4'h0;
        px_pri_d   = 1'b0;
        px_sp0_d   = 1'b0;
        if (w_vis && w_show && w_hit) begin
            px_color_d = {pal_q[w_win], w_pix[w_win]};
            px_pri_d   = pri_q[w_win];
            px_sp0_d   = sp0_q[w_win];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            plane0_q   <= '{default: '0};
            plane1_q   <= '{default: '0};
            xcnt_q     <= '{default: '0};
            pal_q      <= '{default: '0};
            pri_q      <= '0;
            sp0_q      <= '0;
            valid_q    <= '0;
            px_color_q <= 4'h0;
            px_pri_q   <= 1'b0;
            px_sp0_q   <= 1'b0;
        end else begin
            plane0_q   <= plane0_d;
            plane1_q   <= plane1_d;
            xcnt_q     <= xcnt_d;
            pal_q      <= pal_d;
            pri_q      <= pri_d;
            sp0_q      <= sp0_d;
            valid_q    <= valid_d;
            px_color_q <= px_color_d;
            px_pri_q   <= px_pri_d;
            px_sp0_q   <= px_sp0_d;
        end
    end

    assign sp_if.px_color = px_color_q;
    assign sp_if.px_pri   = px_pri_q;
    assign sp_if.px_sp0   = px_sp0_q;

    a_single_load: assert property (@(posedge clk) disable iff (rst)
        !(sp_if.pat_lo_ld && sp_if.pat_hi_ld));

endmodule
`default_nettype wire

// File: tb/tb_sprite_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_shifter
// Purpose  : Scoreboard bench for sprite_shifter against a per-slot pixel model
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_shifter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sprite_shifter_if sp_if ();

    sprite_shifter #(.NSLOTS(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .sp_if (sp_if)
    );

    always #5 clk = ~clk;

    typedef struct { logic [5:0] val; bit first; int cyc; int scan; } exp_t;
    typedef struct { string name; int code; int want; } req_t;

    exp_t exp_q[$];
    req_t req_q[$];
    int   errors = 0;
    int   checks = 0;
    int   hist[18];   // 0..15 colour counts, 16 opaque total, 17 sp0 count

    // Model: a slot is a raw byte pair plus the number of visible dots since its load
    logic [7:0] m_lo[8], m_hi[8], m_attr[8], m_x[8];
    bit         m_flo[8], m_fhi[8], m_zero[8];
    int         m_p[8];

    logic [7:0] cfg_attr[8], cfg_x[8], cfg_lo[8], cfg_hi[8];
    bit         cfg_zero[8], cfg_valid[8], cfg_load[8];

    function automatic logic [1:0] m_pix(input int s);
        int k;
        logic [1:0] r;
        r = 2'b00;
        if (m_p[s] >= int'(m_x[s])) begin
            k = m_p[s] - int'(m_x[s]);
            if (k < 8) begin
                r[1] = m_hi[s][m_fhi[s] ? k : 7 - k];
                r[0] = m_lo[s][m_flo[s] ? k : 7 - k];
            end
        end
        return r;
    endfunction

    task automatic tick();
        int c, sc, sl, w;
        logic [1:0] p;
        logic [5:0] ev;
        bit vis, hit, show;
        @(posedge clk);
        c  = int'(sp_if.cycle);
        sc = int'(sp_if.scan);
        ev = '0;
        if (rst) begin
            for (int s = 0; s < 8; s++) begin
                m_lo[s] = 0; m_hi[s] = 0; m_attr[s] = 0; m_x[s] = 0;
                m_flo[s] = 0; m_fhi[s] = 0; m_zero[s] = 0; m_p[s] = 0;
            end
        end else begin
            vis = sp_if.rend && sc <= 239 && c >= 1 && c <= 256;
            hit = 0; w = 0; p = 0;
            for (int s = 0; s < 8; s++)
                if (!hit && m_pix(s) != 2'b00) begin hit = 1; w = s; p = m_pix(s); end
            show = sp_if.ppumask[4] && ((c - 1) >= 8 || sp_if.ppumask[2]);
            if (vis && show && hit) ev = {m_attr[w][1:0], p, m_attr[w][5], m_zero[w]};
            if (vis) for (int s = 0; s < 8; s++) m_p[s]++;
            if (c >= 256 && c <= 319) begin
                sl = (c - 256) / 8;
                if (sp_if.pat_lo_ld) begin
                    m_lo[sl] = sp_if.pat_din; m_flo[sl] = sp_if.sp_attr[6];
                end else if (sp_if.pat_hi_ld) begin
                    m_hi[sl] = sp_if.pat_din; m_fhi[sl] = sp_if.sp_attr[6];
                    m_attr[sl] = sp_if.sp_attr; m_x[sl] = sp_if.sp_x;
                    m_zero[sl] = sp_if.sp_zero; m_p[sl] = 0;
                    if (!sp_if.sp_valid) begin m_lo[sl] = 0; m_hi[sl] = 0; end
                end
            end
        end
        exp_q.push_back('{val: ev, first: (c == 0), cyc: c, scan: sc});
        #1;
    endtask

    task automatic run_line(input int sc, input bit rd, input logic [7:0] mask,
                            input int rst_cyc, input bit stray);
        for (int c = 0; c < 341; c++) begin
            int s;
            sp_if.cycle     = 9'(c);
            sp_if.scan      = 9'(sc);
            sp_if.rend      = rd;
            sp_if.ppumask   = mask;
            rst             = (c == rst_cyc);
            sp_if.pat_lo_ld = 1'b0;
            sp_if.pat_hi_ld = 1'b0;
            sp_if.pat_din   = 8'($urandom);
            sp_if.sp_attr   = 8'($urandom);
            sp_if.sp_x      = 8'($urandom);
            sp_if.sp_zero   = 1'($urandom);
            sp_if.sp_valid  = 1'($urandom);
            if (c >= 256 && c <= 319) begin
                s = (c - 256) / 8;
                sp_if.sp_attr  = cfg_attr[s];
                sp_if.sp_x     = cfg_x[s];
                sp_if.sp_zero  = cfg_zero[s];
                sp_if.sp_valid = cfg_valid[s];
                if (cfg_load[s] && c == 258 + 8 * s) begin
                    sp_if.pat_lo_ld = 1'b1; sp_if.pat_din = cfg_lo[s];
                end
                if (cfg_load[s] && c == 260 + 8 * s) begin
                    sp_if.pat_hi_ld = 1'b1; sp_if.pat_din = cfg_hi[s];
                end
            end
            if (stray && c == 50)  sp_if.pat_lo_ld = 1'b1;
            if (stray && c == 330) sp_if.pat_hi_ld = 1'b1;
            tick();
        end
    endtask

    task automatic cfg_clear(input bit ld);
        for (int s = 0; s < 8; s++) begin
            cfg_attr[s] = 0; cfg_x[s] = 0; cfg_lo[s] = 0; cfg_hi[s] = 0;
            cfg_zero[s] = 0; cfg_valid[s] = 0; cfg_load[s] = ld;
        end
    endtask

    task automatic cfg_slot(input int s, input logic [7:0] attr, input logic [7:0] x,
                            input logic [7:0] lo, input logic [7:0] hi,
                            input bit zero, input bit valid);
        cfg_attr[s] = attr; cfg_x[s] = x; cfg_lo[s] = lo; cfg_hi[s] = hi;
        cfg_zero[s] = zero; cfg_valid[s] = valid; cfg_load[s] = 1;
    endtask

    task automatic req(input string n, input int code, input int want);
        req_q.push_back('{name: n, code: code, want: want});
    endtask

    always @(negedge clk) begin
        exp_t e;
        req_t q;
        logic [5:0] act;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.first) for (int i = 0; i < 18; i++) hist[i] = 0;
            act = {sp_if.px_color, sp_if.px_pri, sp_if.px_sp0};
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL pixel scan=%0d cycle=%0d: got color=%h pri=%b sp0=%b, want color=%h pri=%b sp0=%b",
                         e.scan, e.cyc, act[5:2], act[1], act[0], e.val[5:2], e.val[1], e.val[0]);
            end
            hist[sp_if.px_color]++;
            if (sp_if.px_color != 4'h0) hist[16]++;
            if (sp_if.px_sp0) hist[17]++;
        end
        while (exp_q.size() == 0 && req_q.size() > 0) begin
            q = req_q.pop_front();
            checks++;
            if (hist[q.code] != q.want) begin
                errors++;
                $display("FAIL %s: got %0d, want %0d", q.name, hist[q.code], q.want);
            end
        end
    end

    initial begin
        logic [7:0] mask;
        sp_if.rend = 0; sp_if.cycle = 0; sp_if.scan = 9'd300; sp_if.ppumask = 0;
        sp_if.sp_attr = 0; sp_if.sp_x = 0; sp_if.sp_zero = 0; sp_if.sp_valid = 0;
        sp_if.pat_din = 0; sp_if.pat_lo_ld = 0; sp_if.pat_hi_ld = 0;
        rst = 1'b1;
        repeat (3) tick();

        cfg_clear(1); cfg_slot(0, 8'h01, 8'd3, 8'h80, 8'h80, 0, 1);
        run_line(10, 1, 8'h14, -1, 0);
        req("idle_after_reset", 16, 0);

        cfg_clear(1); cfg_slot(0, 8'h40, 8'd3, 8'h01, 8'h00, 0, 1);
        run_line(11, 1, 8'h14, -1, 0);
        req("basic_color7", 7, 1); req("basic_opaque", 16, 1);

        cfg_clear(1);
        cfg_slot(0, 8'h02, 8'd10, 8'h0F, 8'h00, 0, 1);
        cfg_slot(1, 8'h03, 8'd10, 8'hFF, 8'h00, 0, 1);
        run_line(12, 1, 8'h14, -1, 0);
        req("hflip_color1", 1, 1); req("hflip_opaque", 16, 1);

        cfg_clear(1); cfg_slot(0, 8'h00, 8'd0, 8'hFF, 8'h00, 1, 1);
        run_line(13, 1, 8'h14, -1, 0);
        req("overlap_colorD", 13, 4); req("overlap_color9", 9, 4); req("overlap_opaque", 16, 8);

        run_line(14, 1, 8'h10, -1, 0);
        req("leftmask_opaque", 16, 0); req("leftmask_sp0", 17, 0);

        cfg_clear(1); cfg_slot(0, 8'h00, 8'd255, 8'h00, 8'h80, 0, 1);
        run_line(15, 1, 8'h14, -1, 0);
        req("left_on_color1", 1, 8); req("left_on_sp0", 17, 8);

        cfg_clear(0);
        run_line(16, 1, 8'h14, -1, 0);
        req("x255_color2", 2, 1); req("x255_opaque", 16, 1);

        cfg_clear(1);
        cfg_slot(0, 8'h00, 8'd5, 8'hFF, 8'hFF, 0, 0);
        cfg_slot(1, 8'h00, 8'd95, 8'hFF, 8'h00, 0, 1);
        run_line(17, 1, 8'h14, -1, 0);
        req("no_wrap_opaque", 16, 0);

        cfg_clear(1);
        run_line(18, 1, 8'h14, 100, 0);
        req("reset_midline_opaque", 16, 4);
        run_line(19, 1, 8'h14, -1, 0);
        req("after_reset_opaque", 16, 0);

        for (int n = 0; n < 16; n++) begin
            for (int s = 0; s < 8; s++) begin
                cfg_attr[s]  = 8'($urandom);
                cfg_x[s]     = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(249, 255))
                                                           : 8'($urandom_range(0, 255));
                cfg_lo[s]    = 8'($urandom);
                cfg_hi[s]    = 8'($urandom);
                cfg_zero[s]  = 1'($urandom);
                cfg_valid[s] = ($urandom_range(0, 3) != 0);
                cfg_load[s]  = ($urandom_range(0, 7) != 0);
            end
            mask = 8'($urandom);
            if ($urandom_range(0, 4) != 0) mask[4] = 1'b1;
            run_line(($urandom_range(0, 5) == 0) ? int'($urandom_range(240, 261))
                                                 : int'($urandom_range(0, 239)),
                     ($urandom_range(0, 7) != 0), mask,
                     ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 340)) : -1, 1);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
